// File: rtl/router_pkg.sv
// Shared router definitions: port count, port indices and arbiter state encoding.
package router_pkg;

    localparam int unsigned PORTS   = 5;

    // Requester bit positions within a request/grant vector.
    localparam int unsigned PORT_XP = 4;
    localparam int unsigned PORT_XM = 3;
    localparam int unsigned PORT_YP = 2;
    localparam int unsigned PORT_YM = 1;
    localparam int unsigned PORT_PE = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        STALL = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning downward from ptr_i
// (wrapping), with an optional override that hands the grant to the pe port.
module rr_pick
    import router_pkg::*;
#(
    parameter int unsigned N = PORTS
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    input  logic                 prio_pe_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 valid_o
);

    localparam int unsigned PW = $clog2(N);

    logic [PW-1:0] cand;

    // Scan ptr, ptr-1, ..., 0, N-1, ...; the first hit wins, pe override on top.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = PW'((32'(ptr_i) + N - k) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
        if (prio_pe_i && req_i[PORT_PE]) begin
            gnt_o          = '0;
            gnt_o[PORT_PE] = 1'b1;
            idx_o          = PW'(PORT_PE);
            valid_o        = 1'b1;
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Per-output-port scheduler: round-robin arbitration with wormhole lock, credit-gated
// flit transfer, one-hot crossbar select and per-inport acknowledge.
// Build option: define LOCAL_PRIORITY_EN to let the pe port win every arbitration it joins.
module output_arbiter
#(
    parameter int unsigned  PORTS   = router_pkg::PORTS,
    parameter int unsigned  CREDITS = 4,
    localparam int unsigned CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] port_rqs,
    input  logic             credit_in,
    output logic [PORTS-1:0] xbar_cfg_vector,
    output logic [PORTS-1:0] arb_ack,
    output logic [CNT_W-1:0] credit_count,
    output logic             credit_err
);

    import router_pkg::*;

    localparam int unsigned PW = $clog2(PORTS);

    state_e           state_q, state_d;
    logic [PORTS-1:0] gnt_q, gnt_d;
    logic [PW-1:0]    gidx_q, gidx_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             transfer;
    logic [PW-1:0]    release_ptr;
    logic [PW-1:0]    pick_ptr;
    logic [PORTS-1:0] pick_gnt;
    logic [PW-1:0]    pick_idx;
    logic             pick_valid;
    logic             prio_pe;

`ifdef LOCAL_PRIORITY_EN
    assign prio_pe = 1'b1;
`else
    assign prio_pe = 1'b0;
`endif

    // After a release the scan restarts just below the port that was served.
    assign release_ptr = (gidx_q == '0) ? PW'(PORTS - 1) : gidx_q - 1'b1;
    assign pick_ptr    = (state_q == IDLE) ? ptr_q : release_ptr;

    rr_pick #(
        .N (PORTS)
    ) u_rr_pick (
        .req_i     (port_rqs),
        .ptr_i     (pick_ptr),
        .prio_pe_i (prio_pe),
        .gnt_o     (pick_gnt),
        .idx_o     (pick_idx),
        .valid_o   (pick_valid)
    );

    // Acknowledge and credit accounting; acks depend only on registered state.
    always_comb begin
        arb_ack  = (state_q == XFER && cnt_q != '0) ? gnt_q : '0;
        transfer = |arb_ack;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (credit_in && !transfer) begin
            if (cnt_q == CNT_W'(CREDITS)) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (transfer && !credit_in) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Grant lock / release and the XFER-vs-STALL decision on next-cycle credits.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_gnt;
                    gidx_d  = pick_idx;
                    state_d = (cnt_d != '0) ? XFER : STALL;
                end
            end
            XFER, STALL: begin
                if (!port_rqs[gidx_q]) begin
                    ptr_d = release_ptr;
                    if (pick_valid) begin
                        gnt_d   = pick_gnt;
                        gidx_d  = pick_idx;
                        state_d = (cnt_d != '0) ? XFER : STALL;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = (cnt_d != '0) ? XFER : STALL;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; x+ gets first priority out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= PW'(PORTS - 1);
            cnt_q   <= CNT_W'(CREDITS);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign xbar_cfg_vector = gnt_q;
    assign credit_count    = cnt_q;
    assign credit_err      = err_q;

endmodule

// File: tb/tb_output_arbiter.sv
// Scoreboard bench for output_arbiter: stimulus pushes expected acks, a negedge monitor
// pops and compares every acknowledged flit; directed checks cover grant/credit state.
module tb_output_arbiter;

    typedef struct packed {
        logic [4:0] ack;
        logic [2:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [4:0] port_rqs;
    logic       credit_in;
    logic [4:0] xbar_cfg_vector;
    logic [4:0] arb_ack;
    logic [2:0] credit_count;
    logic       credit_err;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    output_arbiter #(
        .PORTS   (5),
        .CREDITS (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .port_rqs        (port_rqs),
        .credit_in       (credit_in),
        .xbar_cfg_vector (xbar_cfg_vector),
        .arb_ack         (arb_ack),
        .credit_count    (credit_count),
        .credit_err      (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] ack, input logic [2:0] cnt);
        exp_t e;
        e.ack = ack;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        check("pending_acks", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rst       = 1'b1;
        port_rqs  = '0;
        credit_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_xbar", 32'(xbar_cfg_vector), 32'd0);
        check("rst_ack", 32'(arb_ack), 32'd0);
        check("rst_credit", 32'(credit_count), 32'd4);
        check("rst_err", 32'(credit_err), 32'd0);
    endtask

    // Every acknowledged flit must match the next expected ack vector and credit level.
    always @(negedge clk) begin
        if (rst === 1'b0 && arb_ack != '0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got %b, expected no ack", arb_ack);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_vec", 32'(arb_ack), 32'(mon_e.ack));
                check("ack_credit", 32'(credit_count), 32'(mon_e.cnt));
            end
        end
    end

    initial begin
        logic [4:0] rq;
        logic [4:0] order [3];
        logic [4:0] first_g;

`ifdef LOCAL_PRIORITY_EN
        order[0] = 5'b00001;
        order[1] = 5'b10000;
        order[2] = 5'b00100;
        first_g  = 5'b00001;
`else
        order[0] = 5'b10000;
        order[1] = 5'b00100;
        order[2] = 5'b00001;
        first_g  = 5'b10000;
`endif

        rst       = 1'b1;
        port_rqs  = '0;
        credit_in = 1'b0;
        do_reset();

        // Single pe packet of three flits.
        port_rqs = 5'b00001;
        push(5'b00001, 3'd4);
        push(5'b00001, 3'd3);
        push(5'b00001, 3'd2);
        tick();
        check("t1_grant", 32'(xbar_cfg_vector), 32'b00001);
        tick();
        tick();
        port_rqs = '0;
        tick();
        check("t1_idle_xbar", 32'(xbar_cfg_vector), 32'd0);
        check("t1_credit", 32'(credit_count), 32'd1);
        check("t1_idle_ack", 32'(arb_ack), 32'd0);

        // Three requesters, back-to-back grants, credits returned as flits leave.
        do_reset();
        rq       = 5'b10101;
        port_rqs = rq;
        for (int i = 0; i < 3; i++) begin
            push(order[i], 3'd4);
            push(order[i], 3'd4);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t2_grant_a", 32'(xbar_cfg_vector), 32'(order[i]));
            if (i == 0) credit_in = 1'b1;
            tick();
            check("t2_grant_b", 32'(xbar_cfg_vector), 32'(order[i]));
            rq       = rq & ~order[i];
            port_rqs = rq;
            tick();
        end
        credit_in = 1'b0;
        check("t2_idle_xbar", 32'(xbar_cfg_vector), 32'd0);
        check("t2_credit", 32'(credit_count), 32'd4);
        check("t2_err", 32'(credit_err), 32'd0);

        // Credit stall and recovery on a single returned credit.
        do_reset();
        port_rqs = 5'b00010;
        push(5'b00010, 3'd4);
        push(5'b00010, 3'd3);
        push(5'b00010, 3'd2);
        push(5'b00010, 3'd1);
        tick();
        check("t3_grant", 32'(xbar_cfg_vector), 32'b00010);
        repeat (4) tick();
        check("t3_stall_ack", 32'(arb_ack), 32'd0);
        check("t3_stall_xbar", 32'(xbar_cfg_vector), 32'b00010);
        check("t3_stall_credit", 32'(credit_count), 32'd0);
        tick();
        check("t3_stall_ack2", 32'(arb_ack), 32'd0);
        credit_in = 1'b1;
        push(5'b00010, 3'd1);
        tick();
        credit_in = 1'b0;
        check("t3_resume_ack", 32'(arb_ack), 32'b00010);
        check("t3_resume_credit", 32'(credit_count), 32'd1);
        tick();
        check("t3_restall_credit", 32'(credit_count), 32'd0);
        check("t3_restall_ack", 32'(arb_ack), 32'd0);
        check("t3_restall_xbar", 32'(xbar_cfg_vector), 32'b00010);
        port_rqs = '0;
        tick();
        check("t3_release_xbar", 32'(xbar_cfg_vector), 32'd0);
        check("t3_release_credit", 32'(credit_count), 32'd0);

        // Credit return coinciding with a transfer leaves the count unchanged.
        do_reset();
        port_rqs = 5'b00001;
        push(5'b00001, 3'd4);
        push(5'b00001, 3'd3);
        push(5'b00001, 3'd2);
        push(5'b00001, 3'd2);
        tick();
        tick();
        tick();
        check("t4_credit_pre", 32'(credit_count), 32'd2);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        port_rqs  = '0;
        check("t4_credit_same", 32'(credit_count), 32'd2);
        tick();
        check("t4_credit_post", 32'(credit_count), 32'd1);
        check("t4_idle_xbar", 32'(xbar_cfg_vector), 32'd0);

        // Overflow: saturate and latch the error until reset.
        do_reset();
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        check("t5_credit_sat", 32'(credit_count), 32'd4);
        check("t5_err_set", 32'(credit_err), 32'd1);
        tick();
        tick();
        check("t5_err_sticky", 32'(credit_err), 32'd1);
        do_reset();
        check("t5_err_cleared", 32'(credit_err), 32'd0);

        // x+ and pe together from reset: priority depends on build option.
        port_rqs = 5'b10001;
        push(first_g, 3'd4);
        tick();
        check("t6_grant", 32'(xbar_cfg_vector), 32'(first_g));
        port_rqs = '0;
        tick();
        check("t6_idle_xbar", 32'(xbar_cfg_vector), 32'd0);
        tick();
        check("final_pending", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
